// File: rtl/csa_seq_adder.sv
// Sequential wide adder: one 4-bit carry-select slice reused over WIDTH/4 nibbles, LSB nibble first.
// Define CSA_SEQ_OVF_EN to add a registered two's-complement overflow output (ovf).
module csa_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CSA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] r;
        logic [1:0] fa;
        logic       c;
        r = '0;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            fa   = full_add(x[i], y[i], c);
            r[i] = fa[0];
            c    = fa[1];
        end
        r[4] = c;
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef CSA_SEQ_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic [4:0] slice_c0;
    logic [4:0] slice_c1;
    logic [4:0] slice_res;

    // Carry-select slice: both carry hypotheses computed, registered carry picks one.
    assign slice_c0  = ripple4(a_q[3:0], b_q[3:0], 1'b0);
    assign slice_c1  = ripple4(a_q[3:0], b_q[3:0], 1'b1);
    assign slice_res = carry_q ? slice_c1 : slice_c0;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
`ifdef CSA_SEQ_OVF_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef CSA_SEQ_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                // Nibble enters at the top so the LSB nibble ends up at bit 0 after NSLICE shifts.
                sum_d   = (sum_q >> 4) | (WIDTH'(slice_res[3:0]) << (WIDTH - 4));
                carry_d = slice_res[4];
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_SLICE) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = slice_res[4];
                    cnt_d       = '0;
`ifdef CSA_SEQ_OVF_EN
                    ovf_d       = (a_msb_q == b_msb_q) && (slice_res[3] != a_msb_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef CSA_SEQ_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
`ifdef CSA_SEQ_OVF_EN
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CSA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_seq_adder.sv
// Self-checking bench for csa_seq_adder (WIDTH=16): transaction-level model plus directed vectors.
// Build with CSA_SEQ_OVF_EN defined to also exercise the ovf output.
module tb_csa_seq_adder;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CSA_SEQ_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [W-1:0] res_sum;
    logic         res_cout;
`ifdef CSA_SEQ_OVF_EN
    logic         res_ovf;
`endif

    csa_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CSA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Transaction model: idle -> NSLICE edges of work -> done until out_ready.
    bit           m_idle = 1'b1;
    bit           m_done = 1'b0;
    int           m_cnt  = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [W:0] t;
        if (!rst_n) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            m_cnt  = 0;
        end else if (m_idle) begin
            if (in_valid) begin
                t      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                m_sum  = t[W-1:0];
                m_cout = t[W];
                m_ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
                m_idle = 1'b0;
                m_cnt  = 0;
            end
        end else if (!m_done) begin
            m_cnt++;
            if (m_cnt == NSLICE) m_done = 1'b1;
        end else if (out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("mdl_in_ready", in_ready, m_idle);
            checkOutput("mdl_busy", busy, !m_idle);
            checkOutput("mdl_out_valid", out_valid, m_done);
            if (m_done) begin
                checkOutput("mdl_sum", sum, m_sum);
                checkOutput("mdl_cout", cout, m_cout);
`ifdef CSA_SEQ_OVF_EN
                checkOutput("mdl_ovf", ovf, m_ovf);
`endif
            end
        end
    end

    // Drives one operand set; returns at the negedge following the accept edge.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin);
        int n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_before_accept", in_ready, 1);
        a        = ta;
        b        = tb;
        cin      = tcin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitValid(input bit chk_ready, output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
            if (chk_ready && !out_valid) checkOutput("in_ready_low_in_run", in_ready, 0);
        end
        res_sum  = sum;
        res_cout = cout;
`ifdef CSA_SEQ_OVF_EN
        res_ovf  = ovf;
`endif
    endtask

    task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input int hold, input bit junk);
        int n;
        applyStimulus(ta, tb, tcin);
        if (junk) begin
            a        = 16'hFFFF;
            b        = 16'hFFFF;
            cin      = 1'b1;
            in_valid = 1'b1;
        end
        waitValid(junk, n);
        in_valid = 1'b0;
        checkOutput("latency", n, NSLICE);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_sum", sum, res_sum);
            checkOutput("hold_cout", cout, res_cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("valid_dropped", out_valid, 0);
        checkOutput("in_ready_back", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int c0;
        int c1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #2;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_cout", cout, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        runOp(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        checkOutput("t1_sum", res_sum, 16'h0000);
        checkOutput("t1_cout", res_cout, 1);

        runOp(16'h1234, 16'h4321, 1'b1, 0, 1'b1);
        checkOutput("t2_sum", res_sum, 16'h5556);
        checkOutput("t2_cout", res_cout, 0);

        runOp(16'hAAAA, 16'h5555, 1'b1, 3, 1'b0);
        checkOutput("t3_sum", res_sum, 16'h0000);
        checkOutput("t3_cout", res_cout, 1);

        // Back-to-back with out_ready held high: accept edges six clocks apart.
        out_ready = 1'b1;
        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        c0 = cycle;
        waitValid(1'b0, n);
        checkOutput("b2b_lat1", n, NSLICE);
        checkOutput("b2b_sum1", res_sum, 16'h0100);
        checkOutput("b2b_cout1", res_cout, 0);
        a        = 16'h8000;
        b        = 16'h8000;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_idle_ready", in_ready, 1);
        checkOutput("b2b_idle_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        c1 = cycle;
        checkOutput("b2b_accept_gap", c1 - c0, NSLICE + 2);
        checkOutput("b2b_busy", busy, 1);
        waitValid(1'b0, n);
        checkOutput("b2b_lat2", n, NSLICE);
        checkOutput("b2b_sum2", res_sum, 16'h0000);
        checkOutput("b2b_cout2", res_cout, 1);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second RUN cycle aborts the operation.
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_sum", sum, 0);
        checkOutput("abort_cout", cout, 0);
`ifdef CSA_SEQ_OVF_EN
        checkOutput("abort_ovf", ovf, 0);
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
        runOp(16'h0003, 16'h0004, 1'b0, 0, 1'b0);
        checkOutput("t5_sum", res_sum, 16'h0007);
        checkOutput("t5_cout", res_cout, 0);

`ifdef CSA_SEQ_OVF_EN
        runOp(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        checkOutput("ovf1_sum", res_sum, 16'h8000);
        checkOutput("ovf1_ovf", res_ovf, 1);
        checkOutput("ovf1_cout", res_cout, 0);
        runOp(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
        checkOutput("ovf2_sum", res_sum, 16'hFFFE);
        checkOutput("ovf2_ovf", res_ovf, 0);
        checkOutput("ovf2_cout", res_cout, 1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
